// File: rtl/tournament_bp_pkg.sv
// Shared types, default sizes and the saturating-counter step for the tournament predictor.
package tournament_bp_pkg;

    typedef enum logic [1:0] {
        MODE_TOURN  = 2'b00,
        MODE_LOCAL  = 2'b01,
        MODE_GLOBAL = 2'b10,
        MODE_STATIC = 2'b11
    } mode_e;

    localparam int DEF_PC_W      = 12;
    localparam int DEF_LHT_IDX_W = 10;
    localparam int DEF_LHIST_W   = 10;
    localparam int DEF_LCTR_W    = 3;
    localparam int DEF_GHIST_W   = 12;
    localparam int DEF_GCTR_W    = 2;

    // Widest counter the step helper handles; callers narrow the result to their width.
    localparam int CTR_MAX_W = 8;
    localparam logic [CTR_MAX_W-1:0] CTR_ONE = 1;

    function automatic logic [CTR_MAX_W-1:0] satStep(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic                 up,
        input int unsigned          width
    );
        logic [CTR_MAX_W-1:0] maxVal;
        maxVal = CTR_MAX_W'((1 << width) - 1);
        if (up)
            return (ctr == maxVal) ? ctr : ctr + CTR_ONE;
        return (ctr == '0) ? ctr : ctr - CTR_ONE;
    endfunction

endpackage

// File: rtl/tournament_bp_param_table.sv
// Saturating counter table: combinational read of the taken/select bit, one train port.
module bp_counter_table
    import tournament_bp_pkg::*;
#(
    parameter int               ENTRIES   = 1024,
    parameter int               CTR_W     = 2,
    parameter logic [CTR_W-1:0] RESET_VAL = '0,
    localparam int              IDX_W     = $clog2(ENTRIES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] rdIdx,
    output logic             rdMsb,
    input  logic             wrEn,
    input  logic [IDX_W-1:0] wrIdx,
    input  logic             wrUp
);

    logic [CTR_W-1:0] ctr [ENTRIES];
    logic [CTR_W-1:0] nextCtr;

    assign rdMsb = ctr[rdIdx][CTR_W-1];

    always_comb begin
        nextCtr = CTR_W'(satStep({{(CTR_MAX_W-CTR_W){1'b0}}, ctr[wrIdx]}, wrUp, CTR_W));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr[i] <= RESET_VAL;
        end else if (wrEn) begin
            ctr[wrIdx] <= nextCtr;
        end
    end

endmodule

// File: rtl/tournament_bp_param.sv
// Tournament branch predictor: local/global/choice tables, speculative GHR with repair on mispredict.
module tournament_bp_param
    import tournament_bp_pkg::*;
#(
    parameter int PC_W      = DEF_PC_W,
    parameter int LHT_IDX_W = DEF_LHT_IDX_W,
    parameter int LHIST_W   = DEF_LHIST_W,
    parameter int LCTR_W    = DEF_LCTR_W,
    parameter int GHIST_W   = DEF_GHIST_W,
    parameter int GCTR_W    = DEF_GCTR_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         cfg_mode,
    input  logic               pred_valid,
    input  logic [PC_W-1:0]    pred_pc,
    output logic               pred_out_valid,
    output logic               pred_taken,
    output logic               pred_local,
    output logic               pred_global,
    output logic [GHIST_W-1:0] pred_ghist,
    input  logic               upd_valid,
    input  logic [PC_W-1:0]    upd_pc,
    input  logic               upd_taken,
    input  logic               upd_mispredict,
    input  logic [GHIST_W-1:0] upd_ghist,
    input  logic               upd_local_pred,
    input  logic               upd_global_pred
);

    localparam logic [LCTR_W-1:0] LCTR_RST = LCTR_W'((1 << (LCTR_W - 1)) - 1);
    localparam logic [GCTR_W-1:0] GCTR_RST = GCTR_W'(1);

    logic [LHIST_W-1:0]   lht [2**LHT_IDX_W];
    logic [GHIST_W-1:0]   ghr;
    logic [LHT_IDX_W-1:0] predIdx, updIdx;
    logic [LHIST_W-1:0]   predHist, updHist;
    logic                 localP, globalP, choiceP, takenComb;
    logic                 repair, accept;

    // Only the low PC bits index the history table; aliasing above them is intended.
    if (PC_W > LHT_IDX_W) begin : g_pcAlias
        logic unusedPcBits;
        assign unusedPcBits = ^{pred_pc[PC_W-1:LHT_IDX_W], upd_pc[PC_W-1:LHT_IDX_W]};
    end

    assign predIdx  = pred_pc[LHT_IDX_W-1:0];
    assign updIdx   = upd_pc[LHT_IDX_W-1:0];
    assign predHist = lht[predIdx];
    assign updHist  = lht[updIdx];
    assign repair   = upd_valid & upd_mispredict;
    assign accept   = pred_valid & ~repair;

    always_comb begin
        takenComb = 1'b0;
        case (cfg_mode)
            MODE_TOURN:  takenComb = choiceP ? globalP : localP;
            MODE_LOCAL:  takenComb = localP;
            MODE_GLOBAL: takenComb = globalP;
            default:     takenComb = 1'b0;
        endcase
    end

    bp_counter_table #(.ENTRIES(2**LHIST_W), .CTR_W(LCTR_W), .RESET_VAL(LCTR_RST)) uLpht (
        .clock(clock), .reset(reset),
        .rdIdx(predHist), .rdMsb(localP),
        .wrEn(upd_valid), .wrIdx(updHist), .wrUp(upd_taken)
    );

    bp_counter_table #(.ENTRIES(2**GHIST_W), .CTR_W(GCTR_W), .RESET_VAL(GCTR_RST)) uGpht (
        .clock(clock), .reset(reset),
        .rdIdx(ghr), .rdMsb(globalP),
        .wrEn(upd_valid), .wrIdx(upd_ghist), .wrUp(upd_taken)
    );

    // Choice only learns when the two components disagreed; up means "trust global".
    bp_counter_table #(.ENTRIES(2**GHIST_W), .CTR_W(GCTR_W), .RESET_VAL(GCTR_RST)) uCpht (
        .clock(clock), .reset(reset),
        .rdIdx(ghr), .rdMsb(choiceP),
        .wrEn(upd_valid & (upd_local_pred != upd_global_pred)),
        .wrIdx(upd_ghist), .wrUp(upd_global_pred == upd_taken)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            pred_out_valid <= 1'b0;
            pred_taken     <= 1'b0;
            pred_local     <= 1'b0;
            pred_global    <= 1'b0;
            pred_ghist     <= '0;
            ghr            <= '0;
            for (int i = 0; i < 2**LHT_IDX_W; i++)
                lht[i] <= '0;
        end else begin
            pred_out_valid <= accept;
            if (accept) begin
                pred_taken  <= takenComb;
                pred_local  <= localP;
                pred_global <= globalP;
                pred_ghist  <= ghr;
            end
            // Repair wins over a same-cycle speculative shift, which is squashed.
            if (repair)
                ghr <= {upd_ghist[GHIST_W-2:0], upd_taken};
            else if (accept)
                ghr <= {ghr[GHIST_W-2:0], takenComb};
            if (upd_valid)
                lht[updIdx] <= {updHist[LHIST_W-2:0], upd_taken};
        end
    end

endmodule

// File: tb/tb_tournament_bp_param.sv
// Directed scoreboard bench for tournament_bp_param: expectations queued at issue, checked by a monitor.
module tb_tournament_bp_param;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  cfg_mode;
    logic        pred_valid;
    logic [11:0] pred_pc;
    logic        pred_out_valid, pred_taken, pred_local, pred_global;
    logic [11:0] pred_ghist;
    logic        upd_valid;
    logic [11:0] upd_pc;
    logic        upd_taken, upd_mispredict;
    logic [11:0] upd_ghist;
    logic        upd_local_pred, upd_global_pred;

    typedef struct packed {
        logic        taken;
        logic        pLocal;
        logic        pGlobal;
        logic [11:0] ghist;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    tournament_bp_param dut (
        .clock(clock), .reset(reset), .cfg_mode(cfg_mode),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_out_valid(pred_out_valid), .pred_taken(pred_taken),
        .pred_local(pred_local), .pred_global(pred_global), .pred_ghist(pred_ghist),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .upd_ghist(upd_ghist),
        .upd_local_pred(upd_local_pred), .upd_global_pred(upd_global_pred)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: every presented prediction is matched against the oldest queued expectation.
    always @(negedge clock) begin
        exp_t e;
        if (reset === 1'b0 && pred_out_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pred: got pred_out_valid=1 want no output");
            end else begin
                e = expQ.pop_front();
                chk("pred_taken",  32'(pred_taken),  32'(e.taken));
                chk("pred_local",  32'(pred_local),  32'(e.pLocal));
                chk("pred_global", 32'(pred_global), 32'(e.pGlobal));
                chk("pred_ghist",  32'(pred_ghist),  32'(e.ghist));
            end
        end
    end

    task automatic predict(input logic [11:0] pc, input logic [1:0] mode,
                           input logic t, input logic l, input logic g, input logic [11:0] gh);
        pred_valid = 1'b1;
        pred_pc    = pc;
        cfg_mode   = mode;
        expQ.push_back('{t, l, g, gh});
        @(posedge clock);
        #1 pred_valid = 1'b0;
    endtask

    task automatic update(input logic [11:0] pc, input logic [11:0] gh, input logic taken,
                          input logic misp, input logic lp, input logic gp);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_ghist       = gh;
        upd_taken       = taken;
        upd_mispredict  = misp;
        upd_local_pred  = lp;
        upd_global_pred = gp;
        @(posedge clock);
        #1 upd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_mode = 2'b00;
        pred_valid = 1'b1; pred_pc = 12'h010;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        upd_ghist = '0; upd_local_pred = 1'b0; upd_global_pred = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0; pred_valid = 1'b0;
        @(negedge clock);
        chk("rst_valid", 32'(pred_out_valid), 32'd0);
        chk("rst_taken", 32'(pred_taken), 32'd0);
        chk("rst_ghist", 32'(pred_ghist), 32'd0);

        // Fresh tables: everything weakly not-taken.
        predict(12'h010, 2'b00, 1'b0, 1'b0, 1'b0, 12'h000);

        // Scratch pc 0x100 keeps LPHT[0] at 3 so pc 0x010 stays locally not-taken.
        update(12'h100, 12'h800, 1'b0, 1'b0, 1'b0, 1'b0);
        update(12'h100, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        update(12'h100, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        predict(12'h010, 2'b00, 1'b0, 1'b0, 1'b1, 12'h000);
        predict(12'h010, 2'b11, 1'b0, 1'b0, 1'b1, 12'h000);
        predict(12'h010, 2'b10, 1'b1, 1'b0, 1'b1, 12'h000);

        // Repair GHR back to 0, then teach choice to prefer global at GHR=0.
        update(12'h100, 12'h800, 1'b0, 1'b1, 1'b0, 1'b0);
        update(12'h100, 12'h000, 1'b1, 1'b0, 1'b0, 1'b1);
        predict(12'h010, 2'b00, 1'b1, 1'b0, 1'b1, 12'h000);

        // Repair and request in the same cycle: request squashed.
        pred_valid = 1'b1; pred_pc = 12'h010; cfg_mode = 2'b00;
        upd_valid = 1'b1; upd_pc = 12'h100; upd_ghist = 12'h0A5; upd_taken = 1'b1;
        upd_mispredict = 1'b1; upd_local_pred = 1'b0; upd_global_pred = 1'b0;
        @(posedge clock);
        #1 pred_valid = 1'b0; upd_valid = 1'b0;
        @(negedge clock);
        chk("squash_valid", 32'(pred_out_valid), 32'd0);
        predict(12'h010, 2'b00, 1'b0, 1'b0, 1'b0, 12'h14B);

        // Global counter saturates high then low at GHR=0x3C3.
        update(12'h100, 12'h1E1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (5) update(12'h100, 12'h3C3, 1'b1, 1'b0, 1'b0, 1'b0);
        predict(12'h010, 2'b10, 1'b1, 1'b0, 1'b1, 12'h3C3);
        update(12'h100, 12'h1E1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (5) update(12'h100, 12'h3C3, 1'b0, 1'b0, 1'b0, 1'b0);
        predict(12'h010, 2'b10, 1'b0, 1'b0, 1'b0, 12'h3C3);

        // pc 0x7FF and 0x3FF share LHT entry 0x3FF; eleven takens fill it and train LPHT[0x3FF].
        repeat (11) update(12'h7FF, 12'h800, 1'b1, 1'b0, 1'b0, 1'b0);
        predict(12'h3FF, 2'b01, 1'b1, 1'b1, 1'b0, 12'h786);
        predict(12'h7FF, 2'b01, 1'b1, 1'b1, 1'b0, 12'hF0D);

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
